mem_block_responder: RTL and testbench

- Clocked main-memory responder on the memory side of the cache↔memory interface.
- Accepts one block request (read or write) from the cache controller and waits a programmable access latency.
- Then transfers the 4-word (16-byte) block one word per cycle and pulses done on the last beat.
- Replaces the combinational memory model, so cache miss/write-back timing becomes cycle-accurate.

---
 rtl/mem_block_responder.sv | 78 +++++++
 tb/tb_mem_block_responder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_block_responder.sv
// mem_block_responder: block-oriented main memory with programmable access latency and 4-beat transfers
module mem_block_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       wr_data_i,
    output logic [1:0]        beat_idx_o,
    output logic [31:0]       rd_data_o,
    output logic              rd_valid_o,
    output logic              wr_accept_o,
    output logic              done_o,
    output logic              busy_o
);
    localparam int WORDS = 1 << (ADDR_W - 2);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] XFER = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        beat_q, beat_d;
    logic              write_q, write_d;
    logic [ADDR_W-5:0] blk_q, blk_d;
    logic [31:0]       mem_q [WORDS];
    logic              accept, xfer, unused_addr;

    assign unused_addr = ^req_addr_i[3:0];

    // Next-state logic: accept in IDLE, count down LATENCY cycles, then walk four beats
    always_comb begin
        accept  = (state_q == IDLE) && req_valid_i;
        state_d = accept ? WAIT :
                  (state_q == WAIT && cnt_q == 4'd0) ? XFER :
                  (state_q == XFER && beat_q == 2'd3) ? IDLE : state_q;
        cnt_d   = accept ? 4'(LATENCY - 1) :
                  (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        beat_d  = (state_q == XFER) ? beat_q + 2'd1 : 2'd0;
        write_d = accept ? req_write_i : write_q;
        blk_d   = accept ? req_addr_i[ADDR_W-1:4] : blk_q;
    end

    // Beat outputs are decoded from registered state; read data comes straight from the array
    always_comb begin
        xfer        = state_q == XFER;
        req_ready_o = state_q == IDLE;
        busy_o      = ~req_ready_o;
        rd_valid_o  = xfer && !write_q;
        wr_accept_o = xfer && write_q;
        done_o      = xfer && beat_q == 2'd3;
        beat_idx_o  = xfer ? beat_q : 2'd0;
        rd_data_o   = rd_valid_o ? mem_q[{blk_q, beat_q}] : 32'd0;
    end

    // State registers and memory; reset reloads every word with its own byte address
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            beat_q  <= 2'd0;
            write_q <= 1'b0;
            blk_q   <= '0;
            for (int i = 0; i < WORDS; i++) mem_q[i] <= 32'(i << 2);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            write_q <= write_d;
            blk_q   <= blk_d;
            if (wr_accept_o) mem_q[{blk_q, beat_q}] <= wr_data_i;
        end
    end
endmodule

// File: tb/tb_mem_block_responder.sv
// tb_mem_block_responder: table-driven check of the LATENCY=4 responder plus a LATENCY=1 sequence
module tb_mem_block_responder;
    typedef struct {
        logic        r, v, w;
        logic [9:0]  a;
        logic [31:0] wd;
        logic [38:0] exp;
    } vec_t;

    logic        clk = 0, reset = 1;
    logic        valid = 0, wr = 0;
    logic [9:0]  addr = 0;
    logic [31:0] wdata = 0;
    logic        ready, busy, rv, wa, dn;
    logic [1:0]  bi;
    logic [31:0] rd;
    logic        v1 = 0, ready1, busy1, rv1, wa1, dn1;
    logic [9:0]  a1 = 0;
    logic [1:0]  bi1;
    logic [31:0] rd1;
    int          errors = 0, checks = 0, dcnt = 0, dcnt1 = 0;
    vec_t        q[$];
    logic [31:0] wds [4] = '{32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333};

    mem_block_responder #(.LATENCY(4), .ADDR_W(10)) u0 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(valid), .req_ready_o(ready),
        .req_write_i(wr), .req_addr_i(addr), .wr_data_i(wdata), .beat_idx_o(bi),
        .rd_data_o(rd), .rd_valid_o(rv), .wr_accept_o(wa), .done_o(dn), .busy_o(busy)
    );

    mem_block_responder #(.LATENCY(1), .ADDR_W(10)) u1 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(v1), .req_ready_o(ready1),
        .req_write_i(1'b0), .req_addr_i(a1), .wr_data_i(32'd0), .beat_idx_o(bi1),
        .rd_data_o(rd1), .rd_valid_o(rv1), .wr_accept_o(wa1), .done_o(dn1), .busy_o(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dn) dcnt <= dcnt + 1;
        if (dn1) dcnt1 <= dcnt1 + 1;
    end

    function automatic vec_t mk(logic r, logic v, logic w, logic [9:0] a, logic [31:0] wd,
                                logic rdy, logic erv, logic ewa, logic edn, logic [1:0] ebi,
                                logic [31:0] erd);
        vec_t t;
        t.r = r; t.v = v; t.w = w; t.a = a; t.wd = wd;
        t.exp = {rdy, ~rdy, erv, ewa, edn, ebi, erd};
        return t;
    endfunction

    task automatic chk(string nm, logic [38:0] got, logic [38:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic waits(int n, logic v, logic [9:0] a);
        for (int i = 0; i < n; i++) q.push_back(mk(0, v, 0, a, 0, 0, 0, 0, 0, 2'd0, 0));
    endtask

    task automatic reads(logic [31:0] base, logic v, logic [9:0] a);
        for (int i = 0; i < 4; i++)
            q.push_back(mk(0, v, 0, a, 0, 0, 1, 0, i == 3, 2'(i), base + 32'(4 * i)));
    endtask

    initial begin
        q.push_back(mk(0, 1, 0, 10'h020, 0, 1, 0, 0, 0, 2'd0, 0));
        waits(4, 0, 0);
        reads(32'h20, 0, 0);
        q.push_back(mk(0, 1, 1, 10'h3F0, 0, 1, 0, 0, 0, 2'd0, 0));
        waits(4, 0, 0);
        for (int i = 0; i < 4; i++) q.push_back(mk(0, 0, 0, 0, wds[i], 0, 0, 1, i == 3, 2'(i), 0));
        q.push_back(mk(0, 1, 0, 10'h3F4, 0, 1, 0, 0, 0, 2'd0, 0));
        waits(4, 0, 0);
        for (int i = 0; i < 4; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, i == 3, 2'(i), wds[i]));
        q.push_back(mk(0, 1, 0, 10'h000, 0, 1, 0, 0, 0, 2'd0, 0));
        waits(4, 1, 10'h040);
        reads(32'h0, 1, 10'h040);
        q.push_back(mk(0, 1, 0, 10'h040, 0, 1, 0, 0, 0, 2'd0, 0));
        waits(4, 0, 0);
        reads(32'h40, 0, 0);
        q.push_back(mk(0, 1, 1, 10'h100, 0, 1, 0, 0, 0, 2'd0, 0));
        waits(4, 0, 0);
        q.push_back(mk(0, 0, 0, 0, 32'hAAAA0000, 0, 0, 1, 0, 2'd0, 0));
        q.push_back(mk(1, 0, 0, 0, 32'hAAAA0001, 0, 0, 1, 0, 2'd1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
        q.push_back(mk(0, 1, 0, 10'h100, 0, 1, 0, 0, 0, 2'd0, 0));
        waits(4, 0, 0);
        reads(32'h100, 0, 0);
        q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 0));

        repeat (2) @(negedge clk);
        chk("reset_state", {ready, busy, rv, wa, dn, bi, rd}, {1'b1, 1'b0, 3'b0, 2'd0, 32'd0});
        chk("reset_state_l1", {ready1, busy1, rv1, wa1, dn1, bi1, rd1}, {1'b1, 1'b0, 3'b0, 2'd0, 32'd0});
        reset = 0;
        for (int k = 0; k < q.size(); k++) begin
            if (k > 0) @(negedge clk);
            reset = q[k].r; valid = q[k].v; wr = q[k].w; addr = q[k].a; wdata = q[k].wd;
            #1 chk($sformatf("vec%0d", k), {ready, busy, rv, wa, dn, bi, rd}, q[k].exp);
        end
        chk("done_count", 39'(dcnt), 39'd6);

        @(negedge clk);
        valid = 0; v1 = 1; a1 = 10'h000;
        #1 chk("l1_accept", {ready1, busy1, rv1, wa1, dn1, bi1, rd1}, {1'b1, 1'b0, 3'b0, 2'd0, 32'd0});
        @(negedge clk);
        v1 = 0;
        #1 chk("l1_wait", {ready1, busy1, rv1, wa1, dn1, bi1, rd1}, {1'b0, 1'b1, 3'b0, 2'd0, 32'd0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk($sformatf("l1_beat%0d", i), {ready1, busy1, rv1, wa1, dn1, bi1, rd1},
                   {1'b0, 1'b1, 1'b1, 1'b0, i == 3, 2'(i), 32'(4 * i)});
        end
        @(negedge clk);
        #1 chk("l1_idle", {ready1, busy1, rv1, wa1, dn1, bi1, rd1}, {1'b1, 1'b0, 3'b0, 2'd0, 32'd0});
        chk("l1_done_count", 39'(dcnt1), 39'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
